// File: rtl/ms_section_collector.sv
// Polls NUM_CH slave channels one per cycle, folds the synced samples by sum or
// signed max, and publishes the result on a valid/ready master port and a shared variable.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// SECTION_A | sweep: visit channel ch_idx, fold its sample in if its sync is set
// SECTION_B | publish: copy the accumulated value to m_out and s_out, raise valid
// SECTION_C | emit: hold m_out/valid until the consumer takes the result
module ms_section_collector #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] s_in,
    input  logic [NUM_CH-1:0]        s_in_sync,
    input  logic                     mode_in,
    output logic [DATA_W-1:0]        m_out,
    output logic                     m_out_valid,
    input  logic                     m_out_ready,
    output logic [DATA_W-1:0]        s_out,
    output logic [1:0]               section_out,
    output logic [CH_W-1:0]          ch_idx_out
);

    localparam int HIT_W = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {
        SECTION_A = 2'd0,
        SECTION_B = 2'd1,
        SECTION_C = 2'd2
    } section_t;

    section_t          section_q, section_d;
    logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [HIT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic              mode_lat_q, mode_lat_d;
    logic [DATA_W-1:0] s_out_q, s_out_d;
    logic [DATA_W-1:0] m_out_q, m_out_d;
    logic              m_out_valid_q, m_out_valid_d;

    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] combined;
    logic [HIT_W-1:0]  hit_next;
    logic              mode_eff;
    logic              last_ch;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_data[k] = s_in[k*DATA_W +: DATA_W];
    end

    assign sample   = ch_data[ch_idx_q];
    assign last_ch  = (ch_idx_q == CH_W'(NUM_CH - 1));
    // Channel 0 uses mode_in directly since the latch only updates on that same edge.
    assign mode_eff = (ch_idx_q == '0) ? mode_in : mode_lat_q;

    always_comb begin
        combined = val_q + sample;
        if (mode_eff) begin
            combined = ($signed(sample) > $signed(val_q)) ? sample : val_q;
        end
    end

    always_comb begin
        section_d     = section_q;
        ch_idx_d      = ch_idx_q;
        val_d         = val_q;
        hit_cnt_d     = hit_cnt_q;
        mode_lat_d    = mode_lat_q;
        s_out_d       = s_out_q;
        m_out_d       = m_out_q;
        m_out_valid_d = m_out_valid_q;
        hit_next      = hit_cnt_q;

        case (section_q)
            SECTION_A: begin
                if (ch_idx_q == '0) begin
                    mode_lat_d = mode_in;
                end
                if (s_in_sync[ch_idx_q]) begin
                    val_d    = (hit_cnt_q == '0) ? sample : combined;
                    hit_next = HIT_W'(hit_cnt_q + 1'b1);
                end
                hit_cnt_d = hit_next;
                if (last_ch) begin
                    ch_idx_d = '0;
                    if (hit_next != '0) begin
                        section_d = SECTION_B;
                    end
                end else begin
                    ch_idx_d = CH_W'(ch_idx_q + 1'b1);
                end
            end
            SECTION_B: begin
                s_out_d       = val_q;
                m_out_d       = val_q;
                m_out_valid_d = 1'b1;
                section_d     = SECTION_C;
            end
            SECTION_C: begin
                if (m_out_ready) begin
                    m_out_valid_d = 1'b0;
                    section_d     = SECTION_A;
                    ch_idx_d      = '0;
                    val_d         = '0;
                    hit_cnt_d     = '0;
                end
            end
            default: begin
                section_d = SECTION_A;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            section_q     <= SECTION_A;
            ch_idx_q      <= '0;
            val_q         <= '0;
            hit_cnt_q     <= '0;
            mode_lat_q    <= 1'b0;
            s_out_q       <= '0;
            m_out_q       <= '0;
            m_out_valid_q <= 1'b0;
        end else begin
            section_q     <= section_d;
            ch_idx_q      <= ch_idx_d;
            val_q         <= val_d;
            hit_cnt_q     <= hit_cnt_d;
            mode_lat_q    <= mode_lat_d;
            s_out_q       <= s_out_d;
            m_out_q       <= m_out_d;
            m_out_valid_q <= m_out_valid_d;
        end
    end

    assign m_out       = m_out_q;
    assign m_out_valid = m_out_valid_q;
    assign s_out       = s_out_q;
    assign section_out = section_q;
    assign ch_idx_out  = ch_idx_q;

endmodule

// File: tb/tb_ms_section_collector.sv
// Directed bench for ms_section_collector (NUM_CH=4, DATA_W=32); inputs change and
// outputs are checked on the falling clock edge.
module tb_ms_section_collector;

    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic                     clk;
    logic                     rst;
    logic [NUM_CH*DATA_W-1:0] s_in;
    logic [NUM_CH-1:0]        s_in_sync;
    logic                     mode_in;
    logic [DATA_W-1:0]        m_out;
    logic                     m_out_valid;
    logic                     m_out_ready;
    logic [DATA_W-1:0]        s_out;
    logic [1:0]               section_out;
    logic [CH_W-1:0]          ch_idx_out;

    int checks = 0;
    int errors = 0;

    ms_section_collector #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_in        (s_in),
        .s_in_sync   (s_in_sync),
        .mode_in     (mode_in),
        .m_out       (m_out),
        .m_out_valid (m_out_valid),
        .m_out_ready (m_out_ready),
        .s_out       (s_out),
        .section_out (section_out),
        .ch_idx_out  (ch_idx_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; s_in = '0; s_in_sync = '0; mode_in = 1'b0; m_out_ready = 1'b0;
        wait_neg(3);
        checks++; if (m_out !== 32'd0) begin errors++; $display("FAIL reset_m_out: got %0h expected 0", m_out); end
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", m_out_valid); end
        checks++; if (s_out !== 32'd0) begin errors++; $display("FAIL reset_s_out: got %0h expected 0", s_out); end
        checks++; if (section_out !== 2'd0) begin errors++; $display("FAIL reset_section: got %0d expected 0", section_out); end
        checks++; if (ch_idx_out !== 2'd0) begin errors++; $display("FAIL reset_ch_idx: got %0d expected 0", ch_idx_out); end
        rst = 1'b0;
    endtask

    // Called on a falling edge where the DUT is in SECTION_A at ch0.
    task automatic test_sum;
        s_in = {32'd4, 32'd3, 32'd2, 32'd1}; s_in_sync = 4'b1111; mode_in = 1'b0; m_out_ready = 1'b1;
        wait_neg(1);
        checks++; if (ch_idx_out !== 2'd1) begin errors++; $display("FAIL sum_ch_step: got %0d expected 1", ch_idx_out); end
        wait_neg(3);
        checks++; if (section_out !== 2'd1 || m_out_valid !== 1'b0) begin errors++; $display("FAIL sum_section_b: got sec %0d valid %0b expected sec 1 valid 0", section_out, m_out_valid); end
        wait_neg(1);
        checks++; if (m_out_valid !== 1'b1 || m_out !== 32'd10) begin errors++; $display("FAIL sum_emit: got valid %0b m_out %0d expected valid 1 m_out 10", m_out_valid, m_out); end
        checks++; if (s_out !== 32'd10) begin errors++; $display("FAIL sum_s_out: got %0d expected 10", s_out); end
        checks++; if (section_out !== 2'd2) begin errors++; $display("FAIL sum_section_c: got %0d expected 2", section_out); end
        wait_neg(1);
        checks++; if (section_out !== 2'd0 || m_out_valid !== 1'b0 || ch_idx_out !== 2'd0) begin errors++; $display("FAIL sum_return: got sec %0d valid %0b ch %0d expected 0 0 0", section_out, m_out_valid, ch_idx_out); end
        checks++; if (m_out !== 32'd10) begin errors++; $display("FAIL sum_m_out_kept: got %0d expected 10", m_out); end
    endtask

    task automatic test_max_partial;
        s_in = {32'd7, 32'd100, 32'hFFFF_FFFB, 32'd100}; s_in_sync = 4'b1010; mode_in = 1'b1; m_out_ready = 1'b1;
        wait_neg(2);
        mode_in = 1'b0;
        wait_neg(3);
        checks++; if (m_out_valid !== 1'b1 || m_out !== 32'd7) begin errors++; $display("FAIL max_partial: got valid %0b m_out %0h expected valid 1 m_out 7", m_out_valid, m_out); end
        checks++; if (s_out !== 32'd7) begin errors++; $display("FAIL max_s_out: got %0h expected 7", s_out); end
        wait_neg(1);
    endtask

    task automatic test_backpressure;
        s_in = {32'd4, 32'd3, 32'd2, 32'd1}; s_in_sync = 4'b1111; mode_in = 1'b0; m_out_ready = 1'b0;
        wait_neg(5);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_out_valid !== 1'b1 || m_out !== 32'd10 || section_out !== 2'd2) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid %0b m_out %0d sec %0d expected 1 10 2", i, m_out_valid, m_out, section_out);
            end
            if (i < 2) wait_neg(1);
        end
        m_out_ready = 1'b1;
        wait_neg(1);
        checks++; if (m_out_valid !== 1'b0 || section_out !== 2'd0) begin errors++; $display("FAIL bp_release: got valid %0b sec %0d expected 0 0", m_out_valid, section_out); end
    endtask

    task automatic test_empty_wrap;
        s_in = {32'd9, 32'd9, 32'd9, 32'd9}; s_in_sync = 4'b0000; mode_in = 1'b0; m_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_neg(1);
            checks++;
            if (m_out_valid !== 1'b0 || s_out !== 32'd10 || section_out !== 2'd0 || ch_idx_out !== CH_W'((i + 1) % NUM_CH)) begin
                errors++;
                $display("FAIL empty_sweep[%0d]: got valid %0b s_out %0d sec %0d ch %0d expected 0 10 0 %0d", i, m_out_valid, s_out, section_out, ch_idx_out, (i + 1) % NUM_CH);
            end
        end
        s_in = {32'd0, 32'd0, 32'd1, 32'h7FFF_FFFF}; s_in_sync = 4'b0011;
        wait_neg(5);
        checks++; if (m_out_valid !== 1'b1 || m_out !== 32'h8000_0000) begin errors++; $display("FAIL sum_wrap: got valid %0b m_out %0h expected 1 80000000", m_out_valid, m_out); end
        wait_neg(1);
    endtask

    task automatic test_late_sync;
        s_in = {32'd0, 32'd5, 32'd0, 32'd1000}; s_in_sync = 4'b0100; mode_in = 1'b0; m_out_ready = 1'b0;
        wait_neg(5);
        checks++; if (m_out_valid !== 1'b1 || m_out !== 32'd5) begin errors++; $display("FAIL late_first: got valid %0b m_out %0d expected 1 5", m_out_valid, m_out); end
        s_in_sync = 4'b0101;
        wait_neg(1);
        s_in_sync = 4'b0100; m_out_ready = 1'b1;
        wait_neg(1);
        checks++; if (section_out !== 2'd0 || ch_idx_out !== 2'd0) begin errors++; $display("FAIL late_return: got sec %0d ch %0d expected 0 0", section_out, ch_idx_out); end
        wait_neg(5);
        checks++; if (m_out_valid !== 1'b1 || m_out !== 32'd5) begin errors++; $display("FAIL late_dropped: got valid %0b m_out %0d expected 1 5", m_out_valid, m_out); end
        s_in_sync = 4'b0101;
        wait_neg(6);
        checks++; if (m_out_valid !== 1'b1 || m_out !== 32'd1005) begin errors++; $display("FAIL late_held: got valid %0b m_out %0d expected 1 1005", m_out_valid, m_out); end
        wait_neg(1);
    endtask

    task automatic test_reset_mid_emit;
        s_in = {32'd4, 32'd3, 32'd2, 32'd1}; s_in_sync = 4'b1111; mode_in = 1'b0; m_out_ready = 1'b0;
        wait_neg(5);
        checks++; if (m_out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %0b expected 1", m_out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (m_out_valid !== 1'b0 || section_out !== 2'd0 || m_out !== 32'd0 || s_out !== 32'd0) begin errors++; $display("FAIL rst_async: got valid %0b sec %0d m_out %0d s_out %0d expected all 0", m_out_valid, section_out, m_out, s_out); end
        wait_neg(2);
        rst = 1'b0; m_out_ready = 1'b1;
        checks++; if (ch_idx_out !== 2'd0) begin errors++; $display("FAIL rst_restart_ch: got %0d expected 0", ch_idx_out); end
        wait_neg(4);
        checks++; if (section_out !== 2'd1) begin errors++; $display("FAIL rst_restart_b: got %0d expected 1", section_out); end
        wait_neg(1);
        checks++; if (m_out_valid !== 1'b1 || m_out !== 32'd10) begin errors++; $display("FAIL rst_restart_emit: got valid %0b m_out %0d expected 1 10", m_out_valid, m_out); end
        wait_neg(1);
    endtask

    initial begin
        test_reset();
        test_sum();
        test_max_partial();
        test_backpressure();
        test_empty_wrap();
        test_late_sync();
        test_reset_mid_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ms_section_collector.md
Name: ms_section_collector

Overview:
- Parametrised multi-channel successor to the single-input master/slave section FSM.
- Polls NUM_CH slave shared-variable inputs, each with its own sync flag, one channel per cycle.
- Combines the synced samples by sum or signed max and publishes the result two ways:
  - on a blocking master output with a valid/ready handshake;
  - on a non-blocking shared-variable output.
- Sits between producer channels and a single consumer in the top-level section-based dataflow.

Parameters:
- DATA_W, 32, sample/result width; two's-complement signed.
- NUM_CH, 4, number of slave input channels; must be ≥2.
- CH_W, $clog2(NUM_CH), width of the channel index.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- s_in  in  NUM_CH*DATA_W  channel samples; channel k occupies bits [k*DATA_W +: DATA_W]
- s_in_sync  in  NUM_CH  per-channel sample-valid (sync) flag
- mode_in  in  1  combine mode: 0 = sum, 1 = signed max
- m_out  out  DATA_W  master blocking output data
- m_out_valid  out  1  master output valid
- m_out_ready  in  1  consumer ready
- s_out  out  DATA_W  shared-variable output; holds the last computed result
- section_out  out  2  current section: 0 = SECTION_A, 1 = SECTION_B, 2 = SECTION_C
- ch_idx_out  out  CH_W  channel currently polled

Behaviour:
- Reset (async, rst high): all state returns to reset values immediately.
  - section = SECTION_A, ch_idx = 0, val = 0, hit_cnt = 0, mode_lat = 0.
  - s_out = 0, m_out = 0, m_out_valid = 0.
- SECTION_A (sweep): one channel per cycle, ch_idx = 0..NUM_CH-1.
  - When ch_idx == 0, latch mode_in into mode_lat. Changes to mode_in later in the sweep are ignored.
  - If s_in_sync[ch_idx] = 1:
    - if hit_cnt == 0: val = sample;
    - else: val = val + sample (mode 0, modulo 2^DATA_W, wraps silently) or val = signed max(val, sample) (mode 1);
    - hit_cnt increments.
  - If s_in_sync[ch_idx] = 0, the channel is skipped and its data is ignored.
  - At ch_idx == NUM_CH-1, after processing that channel:
    - if hit_cnt (including this cycle) > 0: go to SECTION_B;
    - else: stay in SECTION_A. This is an empty sweep: no emission, and s_out is unchanged.
    - In both cases ch_idx wraps to 0.
- SECTION_B (one cycle): s_out <= val, m_out <= val, m_out_valid <= 1; go to SECTION_C.
- SECTION_C (emit): m_out_valid = 1.
  - m_out and s_out are held stable while m_out_ready = 0. Stall length is unbounded.
  - On the cycle m_out_ready = 1: the transfer completes. Next cycle m_out_valid = 0, section = SECTION_A, ch_idx = 0, val = 0, hit_cnt = 0.
  - s_out keeps the last result until the next SECTION_B.
- m_out_ready while m_out_valid = 0 is ignored.
- s_in_sync flags are sampled only in SECTION_A. Syncs raised in SECTION_B or SECTION_C are not captured.
- Latency:
  - sweep = NUM_CH cycles;
  - m_out_valid rises NUM_CH+1 cycles after the first sweep cycle;
  - minimum emission period = NUM_CH+2 cycles when ready is held high.
- m_out is not cleared after a transfer; only valid qualifies it.
- section_out and ch_idx_out are registered state, usable for debug and property binding.

Test Plan (NUM_CH=4, DATA_W=32):
- Reset: assert rst → all outputs 0, section_out=0, ch_idx_out=0. Assert rst mid-SECTION_C with valid high → m_out_valid drops without waiting for clk; after release, a full sweep restarts from ch0.
- Sum, all synced, ready=1: s_in = {1,2,3,4}, sync=4'b1111, mode=0 at sweep start → m_out=10 and m_out_valid=1 in cycle 5 (sweep cycles 0–3, SECTION_B in cycle 4); s_out=10; back in SECTION_A in cycle 6.
- Max, partial sync:
  - ch0=100 with sync=0, ch1=-5 with sync=1, ch2=100 with sync=0, ch3=7 with sync=1; mode=1 → m_out=7.
  - Toggle mode_in to 0 at ch_idx=2 → result is still 7.
- Backpressure: m_out_ready=0 for 3 cycles in SECTION_C → m_out_valid and m_out=10 held stable, section_out=2. Raise ready → valid drops next cycle, section_out=0.
- Empty sweep and wrap:
  - sync=0 for a whole sweep → no m_out_valid, s_out keeps its prior value, sweep repeats.
  - Then ch0=0x7FFFFFFF and ch1=1 synced, mode 0 → m_out=0x80000000.
- Late sync: raise sync on ch0 only during SECTION_C → not counted. The next sweep samples it only if it is still asserted when ch_idx=0.
